pe_operand_sequencer: RTL and testbench

- Drives one multiply-accumulate processing element (PE) from the operand side and collects its result.
- Holds a small buffer of (x, w) operand pairs and issues them one at a time.
- Waits the PE pipeline latency D for each result, then feeds the result back as the next partial sum.
- Returns the final dot product plus bias to the host with a done pulse.

---
 rtl/pe_operand_sequencer.sv | 154 +++++++++++++++
 tb/tb_pe_operand_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_operand_sequencer.sv
// Operand sequencer for a single multiply-accumulate PE: issues buffered (x, w) pairs,
// feeds each PE result back as the next partial sum, and returns the final sum plus bias.
//
// state | meaning
// IDLE  | buffer writable, PE operands held at 0, waiting for i_start
// ISSUE | operands for element idx presented to the PE, wait counter loaded
// WAIT  | operands held while the PE pipeline produces the result
// FIN   | o_done pulse with o_result/o_sat, then back to IDLE
module pe_operand_sequencer #(
    parameter int XW    = 8,
    parameter int WW    = 8,
    parameter int BW1   = 16,
    parameter int BW2   = 17,
    parameter int D     = 3,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_wr_en,
    input  logic [AW-1:0]  i_wr_addr,
    input  logic [XW-1:0]  i_wr_x,
    input  logic [WW-1:0]  i_wr_w,
    input  logic [AW:0]    i_len,
    input  logic [BW1-1:0] i_bias,
    input  logic           i_start,
    output logic           o_busy,
    output logic [XW-1:0]  o_pe_x,
    output logic [WW-1:0]  o_pe_w,
    output logic [BW1-1:0] o_pe_psum,
    input  logic [BW2-1:0] i_pe_psum,
    output logic           o_done,
    output logic [BW2-1:0] o_result,
    output logic           o_sat
);

    localparam int CW = $clog2(D + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_t;

    state_t        state;
    logic [XW-1:0] mem_x [DEPTH];
    logic [WW-1:0] mem_w [DEPTH];
    logic [AW:0]   len;
    logic [AW-1:0] idx;
    logic [CW-1:0] cnt;
    logic          sat_run;

    logic [AW:0]    len_clamp;
    logic [AW-1:0]  idx_nxt;
    logic           last;
    logic           ovf;
    logic [BW1-1:0] psum_fb;
    logic [XW-1:0]  x0;
    logic [WW-1:0]  w0;

    always_comb begin
        len_clamp = (i_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : i_len;
        idx_nxt   = idx + AW'(1);
        last      = ({1'b0, idx} == (len - (AW+1)'(1)));
        // Result fits the partial-sum width only if all bits above BW1-1 match the sign.
        ovf       = !((&i_pe_psum[BW2-1:BW1-1]) || !(|i_pe_psum[BW2-1:BW1-1]));
        psum_fb   = i_pe_psum[BW1-1:0];
        if (ovf)
            psum_fb = i_pe_psum[BW2-1] ? {1'b1, {(BW1-1){1'b0}}} : {1'b0, {(BW1-1){1'b1}}};
        // A write to entry 0 in the start cycle must reach the first issue.
        x0 = (i_wr_en && i_wr_addr == '0) ? i_wr_x : mem_x[0];
        w0 = (i_wr_en && i_wr_addr == '0) ? i_wr_w : mem_w[0];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_x[i] <= '0;
                mem_w[i] <= '0;
            end
        end else if (i_wr_en && !o_busy) begin
            mem_x[i_wr_addr] <= i_wr_x;
            mem_w[i_wr_addr] <= i_wr_w;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            len       <= '0;
            idx       <= '0;
            cnt       <= '0;
            sat_run   <= 1'b0;
            o_busy    <= 1'b0;
            o_pe_x    <= '0;
            o_pe_w    <= '0;
            o_pe_psum <= '0;
            o_done    <= 1'b0;
            o_result  <= '0;
            o_sat     <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        len     <= len_clamp;
                        idx     <= '0;
                        sat_run <= 1'b0;
                        if (len_clamp != '0) begin
                            state     <= ISSUE;
                            o_busy    <= 1'b1;
                            o_pe_x    <= x0;
                            o_pe_w    <= w0;
                            o_pe_psum <= i_bias;
                        end else begin
                            state    <= FIN;
                            o_done   <= 1'b1;
                            o_result <= {{(BW2-BW1){i_bias[BW1-1]}}, i_bias};
                            o_sat    <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    cnt   <= CW'(D);
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt == CW'(1)) begin
                        if (last) begin
                            state     <= FIN;
                            o_done    <= 1'b1;
                            o_result  <= i_pe_psum;
                            o_sat     <= sat_run;
                            o_busy    <= 1'b0;
                            o_pe_x    <= '0;
                            o_pe_w    <= '0;
                            o_pe_psum <= '0;
                        end else begin
                            state     <= ISSUE;
                            sat_run   <= sat_run | ovf;
                            idx       <= idx_nxt;
                            o_pe_x    <= mem_x[idx_nxt];
                            o_pe_w    <= mem_w[idx_nxt];
                            o_pe_psum <= psum_fb;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_operand_sequencer.sv
// Randomized bench for pe_operand_sequencer with a delayed ideal PE and a queue-based
// scoreboard fed by an arithmetic reference model of each run.
module tb_pe_operand_sequencer;

    localparam int XW = 8, WW = 8, BW1 = 16, BW2 = 17, D = 3, DEPTH = 8, AW = 3;
    localparam int PMAX = 2 ** (BW1 - 1) - 1;
    localparam int PMIN = -(2 ** (BW1 - 1));

    logic           i_clk = 1'b0;
    logic           i_rst = 1'b1;
    logic           i_wr_en = 1'b0;
    logic [AW-1:0]  i_wr_addr = '0;
    logic [XW-1:0]  i_wr_x = '0;
    logic [WW-1:0]  i_wr_w = '0;
    logic [AW:0]    i_len = '0;
    logic [BW1-1:0] i_bias = '0;
    logic           i_start = 1'b0;
    logic           o_busy;
    logic [XW-1:0]  o_pe_x;
    logic [WW-1:0]  o_pe_w;
    logic [BW1-1:0] o_pe_psum;
    logic [BW2-1:0] i_pe_psum;
    logic           o_done;
    logic [BW2-1:0] o_result;
    logic           o_sat;

    pe_operand_sequencer #(.XW(XW), .WW(WW), .BW1(BW1), .BW2(BW2), .D(D), .DEPTH(DEPTH), .AW(AW)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
        .i_wr_x(i_wr_x), .i_wr_w(i_wr_w), .i_len(i_len), .i_bias(i_bias), .i_start(i_start),
        .o_busy(o_busy), .o_pe_x(o_pe_x), .o_pe_w(o_pe_w), .o_pe_psum(o_pe_psum),
        .i_pe_psum(i_pe_psum), .o_done(o_done), .o_result(o_result), .o_sat(o_sat)
    );

    always #5 i_clk = ~i_clk;

    // Ideal PE: psum + x*w, delayed D cycles.
    logic [BW2-1:0] pipe [D];
    always @(posedge i_clk) begin
        pipe[0] <= BW2'(int'($signed(o_pe_psum)) + int'($signed(o_pe_x)) * int'($signed(o_pe_w)));
        for (int i = 1; i < D; i++) pipe[i] <= pipe[i-1];
    end
    assign i_pe_psum = pipe[D-1];

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct { int res; int sat; int cyc; } exp_t;
    exp_t q[$];

    int total = 0;
    int bad = 0;
    bit mon_en = 1'b0;
    int mx [DEPTH];
    int mw [DEPTH];
    int ex_x [DEPTH];
    int ex_w [DEPTH];
    int ex_p [DEPTH];
    int bstart = 1;
    int bend = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: sequential dot product with clipped feedback, scheduled by cycle.
    task automatic model(input int len, input int bias, input int s);
        int n, acc, sat, fin, r;
        exp_t e;
        n = (len > DEPTH) ? DEPTH : len;
        acc = bias; sat = 0; fin = bias;
        for (int k = 0; k < n; k++) begin
            ex_x[k] = mx[k]; ex_w[k] = mw[k]; ex_p[k] = acc;
            r = acc + mx[k] * mw[k];
            if (k == n - 1) fin = r;
            else if (r > PMAX) begin acc = PMAX; sat = 1; end
            else if (r < PMIN) begin acc = PMIN; sat = 1; end
            else acc = r;
        end
        e.res = fin; e.sat = sat; e.cyc = s + 1 + n * (D + 1);
        q.push_back(e);
        bstart = s + 1;
        bend = s + n * (D + 1);
    endtask

    always @(negedge i_clk) begin
        int k;
        bit eb;
        exp_t e;
        if (mon_en) begin
            eb = (cyc >= bstart) && (cyc <= bend);
            chk("busy", int'(o_busy), int'(eb));
            if (eb) begin
                k = (cyc - bstart) / (D + 1);
                chk("pe_x", int'($signed(o_pe_x)), ex_x[k]);
                chk("pe_w", int'($signed(o_pe_w)), ex_w[k]);
                chk("pe_psum", int'($signed(o_pe_psum)), ex_p[k]);
            end else begin
                chk("pe_x_idle", int'(o_pe_x), 0);
                chk("pe_w_idle", int'(o_pe_w), 0);
                chk("pe_psum_idle", int'(o_pe_psum), 0);
            end
            if (o_done) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: got o_done=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e = q.pop_front();
                    chk("result", int'($signed(o_result)), e.res);
                    chk("sat", int'(o_sat), e.sat);
                    chk("done_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    task automatic set_wr(input int a, input int x, input int w);
        i_wr_en = 1'b1; i_wr_addr = AW'(a); i_wr_x = XW'(x); i_wr_w = WW'(w);
        if (!((cyc >= bstart) && (cyc <= bend))) begin mx[a] = x; mw[a] = w; end
    endtask

    task automatic wr(input int a, input int x, input int w);
        set_wr(a, x, w);
        tick();
        i_wr_en = 1'b0;
    endtask

    task automatic set_start(input int len, input int bias);
        i_len = (AW+1)'(len); i_bias = BW1'(bias); i_start = 1'b1;
        model(len, bias, cyc);
    endtask

    task automatic go(input int len, input int bias);
        set_start(len, bias);
        tick();
        i_start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin tick(); n++; end
        if (q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", q.size());
            q.delete();
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        for (int i = 0; i < DEPTH; i++) begin mx[i] = 0; mw[i] = 0; end
        repeat (3) tick();
        i_rst = 1'b0;
        mon_en = 1'b1;
        tick();
        chk("rst_result", int'(o_result), 0);
        chk("rst_sat", int'(o_sat), 0);
        chk("rst_done", int'(o_done), 0);

        wr(0, 1, 5); wr(1, 2, 6); wr(2, 3, 7);
        go(3, 10); drain();

        wr(0, 127, 127); wr(1, 127, 127);
        go(2, 32767); drain();

        wr(0, -128, 127); wr(1, -128, 127);
        go(2, -32768); drain();

        go(0, -5); drain();
        go(12, 7); drain();

        // Write and start in the same cycle: the run sees the new entry 0.
        set_wr(0, -3, 9);
        set_start(2, 100);
        tick();
        i_wr_en = 1'b0; i_start = 1'b0;
        drain();

        // Write and start while busy are both ignored.
        go(3, 1);
        repeat (3) tick();
        wr(0, 50, 50);
        i_len = 4'd5; i_bias = 16'd999; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        drain();
        go(1, 0); drain();

        // Reset during WAIT of element 1 aborts the run and clears the buffer.
        wr(1, 4, 4);
        s = cyc;
        go(3, 20);
        while (cyc < s + D + 3) tick();
        i_rst = 1'b1;
        bend = cyc;
        q.delete();
        tick();
        i_rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin mx[i] = 0; mw[i] = 0; end
        chk("rst_mid_result", int'(o_result), 0);
        tick();
        go(4, 123); drain();

        for (int it = 0; it < 25; it++) begin
            int nw, bias, len;
            nw = $urandom_range(0, 4);
            for (int j = 0; j < nw; j++)
                wr($urandom_range(0, DEPTH - 1), $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128);
            bias = $urandom_range(0, 65535) - 32768;
            if ($urandom_range(0, 3) == 0) bias = ($urandom_range(0, 1) == 1) ? PMAX : PMIN;
            len = $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) begin
                set_wr($urandom_range(0, DEPTH - 1), $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128);
                set_start(len, bias);
                tick();
                i_wr_en = 1'b0; i_start = 1'b0;
            end else begin
                go(len, bias);
            end
            drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
